// File: rtl/rr_queue_arbiter_pkg.sv
// Shared types, defaults and the reference round-robin scan for rr_queue_arbiter.
package rr_arb_pkg;

  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = 8;
  localparam int MAX_N     = 8;
  localparam int IDX_MAX_W = 3;

  // Index fields are sized for the largest supported N; narrower builds use the low bits.
  typedef struct packed {
    logic [IDX_MAX_W-1:0] last_grant;
    logic                 locked;
    logic [IDX_MAX_W-1:0] lock_id;
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [IDX_MAX_W-1:0] idx;
  } pick_t;

  function automatic pick_t next_rr_idx(input logic [MAX_N-1:0]     valid_vec,
                                        input logic [IDX_MAX_W-1:0] last_grant,
                                        input int                   n);
    pick_t r;
    int    cand;
    r.found = 1'b0;
    r.idx   = IDX_MAX_W'((int'(last_grant) + 1) % n);
    for (int k = 1; k <= MAX_N; k++) begin
      cand = (int'(last_grant) + k) % n;
      if (k <= n && !r.found && valid_vec[cand[IDX_MAX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = IDX_MAX_W'(cand);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_queue_arbiter_if.sv
// Requester-side and queue-side handshake bundle of rr_queue_arbiter.
// io_hi_pri exists only when RR_QUEUE_ARBITER_PRIORITY_EN is defined.
interface rr_queue_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int W   = W_DEFAULT,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   io_in_valid;
  logic [N-1:0]   io_in_ready;
  logic [N*W-1:0] io_in_bits;
  logic [N-1:0]   io_in_last;
  logic           io_out_valid;
  logic           io_out_ready;
  logic [W-1:0]   io_out_bits;
  logic           io_out_last;
  logic [IDW-1:0] io_chosen;
`ifdef RR_QUEUE_ARBITER_PRIORITY_EN
  logic [N-1:0]   io_hi_pri;
`endif

  modport master (
`ifdef RR_QUEUE_ARBITER_PRIORITY_EN
    input  io_hi_pri,
`endif
    input  io_in_valid, io_in_bits, io_in_last, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen
  );

  modport slave (
`ifdef RR_QUEUE_ARBITER_PRIORITY_EN
    output io_hi_pri,
`endif
    output io_in_valid, io_in_bits, io_in_last, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen
  );
endinterface

// File: rtl/rr_queue_arbiter_rr_pick.sv
// Unlocked round-robin selection: rotate valids so last_grant+1 sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last_grant,
  output logic [IDW-1:0] idx
);
  logic [IDW-1:0] start;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rotated;
  logic [IDW-1:0] offset;
  logic [IDW:0]   sum;

  assign start   = (last_grant == IDW'(N - 1)) ? '0 : last_grant + IDW'(1);
  assign shifted = {valid, valid} >> start;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rotated[gi] = shifted[gi];
  end

  // With nothing valid the offset stays 0, so idx falls back to last_grant+1.
  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDW'(i);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (IDW + 1)'(N)) idx = IDW'(sum - (IDW + 1)'(N));
    else                      idx = IDW'(sum);
  end
endmodule

// File: rtl/rr_queue_arbiter.sv
// Round-robin arbiter with packet locking in front of a shared enqueue port.
// Define RR_QUEUE_ARBITER_PRIORITY_EN to add io_hi_pri override while unlocked.
module rr_queue_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int W   = W_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  rr_queue_arbiter_if.master  bus
);
  arb_state_t     state_reg, state_next;
  logic [IDW-1:0] rr_idx;
  logic [IDW-1:0] unlocked_idx;
  logic [IDW-1:0] chosen;
  logic           fire;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .valid      (bus.io_in_valid),
    .last_grant (state_reg.last_grant[IDW-1:0]),
    .idx        (rr_idx)
  );

`ifdef RR_QUEUE_ARBITER_PRIORITY_EN
  pick_t hp_pick;
  logic  unused_hp_bits;
  // Scanning from N-1 makes the reference scan start at index 0, i.e. lowest index wins.
  assign hp_pick        = next_rr_idx(MAX_N'(bus.io_in_valid & bus.io_hi_pri), IDX_MAX_W'(N - 1), N);
  assign unlocked_idx   = hp_pick.found ? hp_pick.idx[IDW-1:0] : rr_idx;
  assign unused_hp_bits = ^hp_pick;
`else
  assign unlocked_idx = rr_idx;
`endif

  assign chosen           = state_reg.locked ? state_reg.lock_id[IDW-1:0] : unlocked_idx;
  assign bus.io_chosen    = chosen;
  assign bus.io_out_valid = bus.io_in_valid[chosen];
  assign bus.io_out_bits  = bus.io_in_bits[chosen*W +: W];
  assign bus.io_out_last  = bus.io_in_last[chosen];
  assign fire             = bus.io_out_valid && bus.io_out_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.io_in_ready[gi] = bus.io_out_ready && (chosen == IDW'(gi));
  end

  always_comb begin
    state_next = state_reg;
    if (fire) begin
      state_next.last_grant = IDX_MAX_W'(chosen);
      if (bus.io_out_last) begin
        state_next.locked = 1'b0;
      end else begin
        state_next.locked  = 1'b1;
        state_next.lock_id = IDX_MAX_W'(chosen);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg.last_grant <= IDX_MAX_W'(N - 1);
      state_reg.locked     <= 1'b0;
      state_reg.lock_id    <= '0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Upper index bits above IDW are never read in narrower builds.
  logic unused_state_bits;
  assign unused_state_bits = ^state_reg;
endmodule

// File: tb/tb_rr_queue_arbiter.sv
// Directed bench for rr_queue_arbiter: stimulus queues expected beats, a monitor checks them.
module tb_rr_queue_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [1:0] chosen;
    logic [7:0] bits;
    logic       last;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset;
  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];

  rr_queue_arbiter_if #(.N(N), .W(W)) bus ();

  rr_queue_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input int i, input logic [7:0] v);
    bus.io_in_bits[i*W +: W] = v;
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] b, input logic l);
    beat_t e;
    e.chosen = c;
    e.bits   = b;
    e.last   = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted beat must match the next expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && bus.io_out_valid === 1'b1 && bus.io_out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got chosen=%0d bits=0x%0h required none", bus.io_chosen, bus.io_out_bits);
      end else begin
        e = exp_q.pop_front();
        $display("beat: chosen=%0d bits=0x%02h last=%0b (expect %0d/0x%02h/%0b)",
                 bus.io_chosen, bus.io_out_bits, bus.io_out_last, e.chosen, e.bits, e.last);
        check("beat_chosen", 32'(bus.io_chosen), 32'(e.chosen));
        check("beat_bits", 32'(bus.io_out_bits), 32'(e.bits));
        check("beat_last", 32'(bus.io_out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = '0;
    bus.io_in_last   = '0;
    bus.io_in_bits   = '0;
`ifdef RR_QUEUE_ARBITER_PRIORITY_EN
    bus.io_hi_pri    = '0;
`endif
    for (int i = 0; i < N; i++) set_bits(i, 8'(8'h10 + i));
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
    check("rst_chosen", 32'(bus.io_chosen), 32'd0);
    check("rst_in_ready", 32'(bus.io_in_ready), 32'd0);

    // Single beat from requester 2, zero latency.
    step();
    bus.io_in_valid  = 4'b0100;
    bus.io_in_last   = 4'b0100;
    set_bits(2, 8'h5A);
    bus.io_out_ready = 1'b1;
    push(2'd2, 8'h5A, 1'b1);
    @(negedge clk);
    check("t1_out_bits", 32'(bus.io_out_bits), 32'h5A);
    check("t1_in_ready", 32'(bus.io_in_ready), 32'b0100);
    step();
    bus.io_in_valid  = '0;
    bus.io_out_ready = 1'b0;
    reset            = 1'b1;
    step();
    reset = 1'b0;

    // All four valid, single-beat packets: plain rotation.
    bus.io_in_valid  = 4'b1111;
    bus.io_in_last   = 4'b1111;
    set_bits(2, 8'h12);
    bus.io_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      push(2'(c % 4), 8'(8'h10 + c % 4), 1'b1);
      step();
    end

    // Three-beat packet from requester 1 with a bubble on beat 2.
    bus.io_in_valid = 4'b1010;
    bus.io_in_last  = 4'b1000;
    set_bits(1, 8'hB1);
    push(2'd1, 8'hB1, 1'b0);
    step();
    bus.io_in_valid = 4'b1001;
    @(negedge clk);
    check("bubble_chosen", 32'(bus.io_chosen), 32'd1);
    check("bubble_out_valid", 32'(bus.io_out_valid), 32'd0);
    check("bubble_in_ready", 32'(bus.io_in_ready), 32'b0010);
    step();
    bus.io_in_valid = 4'b1011;
    set_bits(1, 8'hB2);
    push(2'd1, 8'hB2, 1'b0);
    step();
    set_bits(1, 8'hB3);
    bus.io_in_last = 4'b1010;
    push(2'd1, 8'hB3, 1'b1);
    step();
    bus.io_in_valid = 4'b1001;
    set_bits(1, 8'h11);
    push(2'd3, 8'h13, 1'b1);
    step();

    // Queue full: nothing moves, selection stable.
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 4'b1010;
    bus.io_in_last   = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("full_in_ready", 32'(bus.io_in_ready), 32'd0);
      check("full_chosen", 32'(bus.io_chosen), 32'd1);
      step();
    end
    bus.io_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push((c % 2 == 0) ? 2'd1 : 2'd3, (c % 2 == 0) ? 8'h11 : 8'h13, 1'b1);
      step();
    end

    // Reset while locked to requester 2.
    bus.io_in_valid = 4'b0100;
    bus.io_in_last  = 4'b0000;
    set_bits(2, 8'hC2);
    push(2'd2, 8'hC2, 1'b0);
    step();
    reset            = 1'b1;
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 4'b0101;
    bus.io_in_last   = 4'b1111;
    step();
    reset            = 1'b0;
    bus.io_out_ready = 1'b1;
    push(2'd0, 8'h10, 1'b1);
    @(negedge clk);
    check("post_reset_chosen", 32'(bus.io_chosen), 32'd0);
    check("post_reset_out_valid", 32'(bus.io_out_valid), 32'd1);
    step();

`ifdef RR_QUEUE_ARBITER_PRIORITY_EN
    bus.io_in_valid = 4'b1111;
    bus.io_hi_pri   = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      push(2'd3, 8'h13, 1'b1);
      step();
    end
    bus.io_hi_pri = 4'b0000;
    push(2'd0, 8'h10, 1'b1);
    step();
    push(2'd1, 8'h11, 1'b1);
    step();
`endif

    bus.io_in_valid  = '0;
    bus.io_out_ready = 1'b0;
    step();
    step();
    check("pending_beats", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
